// File: rtl/key_expansion_seq_pkg.sv
// rtl/key_expansion_seq_pkg.sv - S-box, Rcon constants, legal Nk/Nr pairs and FSM encoding for key_expansion_seq
package key_expansion_seq_pkg;

   // Legal (Nk, Nr) pairs: AES-128, AES-192, AES-256
   localparam int NK_AES128 = 4;
   localparam int NR_AES128 = 10;
   localparam int NK_AES192 = 6;
   localparam int NR_AES192 = 12;
   localparam int NK_AES256 = 8;
   localparam int NR_AES256 = 14;

   // Round constant seed and GF(2^8) reduction polynomial used by xtime
   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_POLY = 8'h1B;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_t;

   // AES forward S-box, entry 0x00 in the MSBs
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
   endfunction

   // Multiply by x in GF(2^8); advances the round constant
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ RCON_POLY) : {b[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/key_expansion_seq_sub_word.sv
// rtl/key_expansion_seq_sub_word.sv - combinational 4-byte S-box lookup on a 32-bit word
module key_expansion_seq_sub_word
   import key_expansion_seq_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub
);

   // Substitute each byte independently through the AES S-box
   always_comb begin
      sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
   end

endmodule

// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - iterative AES key schedule, one word per clock; KEY_EXP_ROUND_VALID_EN adds round_valid
module key_expansion_seq
   import key_expansion_seq_pkg::*;
#(
   parameter int Nk = NK_AES128,
   parameter int Nr = NR_AES128
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [Nk*32-1:0]       key,
   input  logic                   start,
   output logic [(Nr+1)*128-1:0]  allKeys,
   output logic                   busy,
   output logic                   done,
   output logic                   keys_valid
`ifdef KEY_EXP_ROUND_VALID_EN
   ,
   output logic [Nr:0]            round_valid
`endif
);

   localparam int NW = 4 * (Nr + 1);
   localparam int IW = $clog2(NW);
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
   localparam logic [2:0]    MOD_LAST = 3'(Nk - 1);

   // An unsupported Nk/Nr pairing never leaves IDLE, so allKeys stays zero
   localparam bit CFG_LEGAL = (Nk == NK_AES128 && Nr == NR_AES128) ||
                              (Nk == NK_AES192 && Nr == NR_AES192) ||
                              (Nk == NK_AES256 && Nr == NR_AES256);

   state_t          state;
   state_t          next_state;
   logic            accept;
   logic            step;
   logic            finish;

   logic [IW-1:0]   i_cnt;
   logic [2:0]      mod_cnt;
   logic [7:0]      rcon;
   logic [31:0]     win   [0:Nk-1];
   logic [31:0]     words [0:NW-1];

   logic [31:0]     prev;
   logic [31:0]     sub_in;
   logic [31:0]     sub_out;
   logic [31:0]     temp;
   logic [31:0]     new_word;
   logic            is_rot;
   logic            is_sub;

   assign busy = (state == ST_EXPAND);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-edge strobes; start is only looked at in IDLE
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && CFG_LEGAL) begin
               accept     = 1'b1;
               next_state = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            step = 1'b1;
            if (i_cnt == LAST_IDX) begin
               finish     = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // One shared S-box: fed RotWord(w[i-1]) on round boundaries, w[i-1] otherwise
   always_comb begin
      prev     = win[Nk-1];
      is_rot   = (mod_cnt == 3'd0);
      is_sub   = (Nk > 6) && (mod_cnt == 3'd4);
      sub_in   = is_rot ? {prev[23:0], prev[31:24]} : prev;
      temp     = prev;
      if (is_rot) begin
         temp = sub_out ^ {rcon, 24'h0};
      end else if (is_sub) begin
         temp = sub_out;
      end
      new_word = win[0] ^ temp;
   end

   key_expansion_seq_sub_word u_sub_word (
      .word (sub_in),
      .sub  (sub_out)
   );

   // Word index, mod-Nk position and round constant
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_cnt   <= '0;
         mod_cnt <= 3'd0;
         rcon    <= RCON_INIT;
      end else if (accept) begin
         i_cnt   <= IW'(Nk);
         mod_cnt <= 3'd0;
         rcon    <= RCON_INIT;
      end else if (step) begin
         i_cnt   <= i_cnt + 1'b1;
         mod_cnt <= (mod_cnt == MOD_LAST) ? 3'd0 : mod_cnt + 3'd1;
         if (mod_cnt == 3'd0) begin
            rcon <= xtime(rcon);
         end
      end
   end

   // Sliding window of the last Nk words: win[0] is w[i-Nk], win[Nk-1] is w[i-1]
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < Nk; j++) begin
            win[j] <= '0;
         end
      end else if (accept) begin
         for (int j = 0; j < Nk; j++) begin
            win[j] <= key[Nk*32-1-32*j -: 32];
         end
      end else if (step) begin
         for (int j = 0; j < Nk - 1; j++) begin
            win[j] <= win[j+1];
         end
         win[Nk-1] <= new_word;
      end
   end

   // Schedule storage: cleared and seeded with the key on start, one word written per step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int g = 0; g < NW; g++) begin
            words[g] <= '0;
         end
      end else if (accept) begin
         for (int g = 0; g < NW; g++) begin
            words[g] <= '0;
         end
         for (int j = 0; j < Nk; j++) begin
            words[j] <= key[Nk*32-1-32*j -: 32];
         end
      end else if (step) begin
         for (int g = 0; g < NW; g++) begin
            if (i_cnt == IW'(g)) begin
               words[g] <= new_word;
            end
         end
      end
   end

   // Completion pulse and the level that releases the encrypt core
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done       <= 1'b0;
         keys_valid <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            keys_valid <= 1'b0;
         end else if (finish) begin
            keys_valid <= 1'b1;
         end
      end
   end

`ifdef KEY_EXP_ROUND_VALID_EN
   // Per-round ready flags: round r is usable once word 4r+3 exists
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         round_valid <= '0;
      end else if (accept) begin
         for (int r = 0; r <= Nr; r++) begin
            round_valid[r] <= (4 * r + 3 < Nk);
         end
      end else if (step) begin
         for (int r = 0; r <= Nr; r++) begin
            if (i_cnt == IW'(4 * r + 3)) begin
               round_valid[r] <= 1'b1;
            end
         end
      end
   end
`endif

   // Round 0 key in the MSBs, w[i] descending through the bus
   for (genvar g = 0; g < NW; g++) begin : g_pack
      assign allKeys[(Nr+1)*128-1-32*g -: 32] = words[g];
   end

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - directed self-checking bench for key_expansion_seq (AES-128/192/256)
module tb_key_expansion_seq;

   localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic [127:0]   key_a;
   logic           start_a;
   logic [1407:0]  keys_a;
   logic           busy_a, done_a, kv_a;
   logic [191:0]   key_b;
   logic           start_b;
   logic [1663:0]  keys_b;
   logic           busy_b, done_b, kv_b;
   logic [255:0]   key_c;
   logic           start_c;
   logic [1919:0]  keys_c;
   logic           busy_c, done_c, kv_c;
`ifdef KEY_EXP_ROUND_VALID_EN
   logic [10:0]    rv_a;
   logic [12:0]    rv_b;
   logic [14:0]    rv_c;
`endif

   int tests = 0;
   int fails = 0;
   int n;

   key_expansion_seq #(.Nk(4), .Nr(10)) dut_a (
      .clk(clk), .reset(reset), .key(key_a), .start(start_a), .allKeys(keys_a),
      .busy(busy_a), .done(done_a), .keys_valid(kv_a)
`ifdef KEY_EXP_ROUND_VALID_EN
      , .round_valid(rv_a)
`endif
   );

   key_expansion_seq #(.Nk(6), .Nr(12)) dut_b (
      .clk(clk), .reset(reset), .key(key_b), .start(start_b), .allKeys(keys_b),
      .busy(busy_b), .done(done_b), .keys_valid(kv_b)
`ifdef KEY_EXP_ROUND_VALID_EN
      , .round_valid(rv_b)
`endif
   );

   key_expansion_seq #(.Nk(8), .Nr(14)) dut_c (
      .clk(clk), .reset(reset), .key(key_c), .start(start_c), .allKeys(keys_c),
      .busy(busy_c), .done(done_c), .keys_valid(kv_c)
`ifdef KEY_EXP_ROUND_VALID_EN
      , .round_valid(rv_c)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rk_a(input int r);
      return keys_a[1407-128*r -: 128];
   endfunction

   // Drive start for one edge on the selected instance; returns #1 after that edge (edge 0)
   task automatic pulse(input int sel);
      @(negedge clk);
      case (sel)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   // Count edges until done is seen, bounded
   task automatic wait_done(input int sel, output int cnt);
      logic d;
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
         d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      end while (!d && cnt < 120);
   endtask

   initial begin
      reset   = 1'b0;
      key_a   = KEY128;
      key_b   = KEY192;
      key_c   = KEY256;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check1("rst_allkeys_zero", |keys_a, 1'b0);
      check1("rst_busy", busy_a, 1'b0);
      check1("rst_done", done_a, 1'b0);
      check1("rst_keys_valid", kv_a, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // AES-128 single start pulse
      pulse(0);
      check1("a_busy_after_start", busy_a, 1'b1);
      check1("a_kv_after_start", kv_a, 1'b0);
      check("a_round0", rk_a(0), KEY128);
      check("a_round1_unwritten", rk_a(1), 128'h0);
`ifdef KEY_EXP_ROUND_VALID_EN
      check("a_rv_edge0", 128'(rv_a), 128'h001);
`endif
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
`ifdef KEY_EXP_ROUND_VALID_EN
         if (n == 3) check("a_rv_edge3", 128'(rv_a), 128'h001);
         if (n == 4) check("a_rv_edge4", 128'(rv_a), 128'h003);
`endif
      end while (!done_a && n < 120);
      check("a_latency", 128'(n), 128'd40);
      check1("a_kv_at_done", kv_a, 1'b1);
      check1("a_busy_at_done", busy_a, 1'b0);
      check("a_round1", rk_a(1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      check("a_round10", rk_a(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
`ifdef KEY_EXP_ROUND_VALID_EN
      check("a_rv_done", 128'(rv_a), 128'h7FF);
`endif
      @(posedge clk);
      #1;
      check1("a_done_one_cycle", done_a, 1'b0);
      check1("a_kv_holds", kv_a, 1'b1);

      // AES-192
      pulse(1);
      check1("b_busy_after_start", busy_b, 1'b1);
      wait_done(1, n);
      check("b_latency", 128'(n), 128'd46);
      check("b_round0", keys_b[1663 -: 128], KEY192[191:64]);
      check("b_round12", keys_b[127:0], 128'ha4970a331a78dc09c418c271e3a41d5d);
      check1("b_kv_at_done", kv_b, 1'b1);
`ifdef KEY_EXP_ROUND_VALID_EN
      check("b_rv_done", 128'(rv_b), 128'h1FFF);
`endif

      // AES-256
      pulse(2);
      check1("c_busy_after_start", busy_c, 1'b1);
      wait_done(2, n);
      check("c_latency", 128'(n), 128'd52);
      check("c_round0", keys_c[1919 -: 128], KEY256[255:128]);
      check("c_round14", keys_c[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      check1("c_kv_at_done", kv_c, 1'b1);
`ifdef KEY_EXP_ROUND_VALID_EN
      check("c_rv_done", 128'(rv_c), 128'h7FFF);
`endif

      // AES-128, start re-asserted with a different key at edge 20: ignored
      pulse(0);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 19) begin
            start_a = 1'b1;
            key_a   = 128'hffeeddccbbaa99887766554433221100;
         end
         if (n == 20) start_a = 1'b0;
         if (n == 21) check1("r_busy_after_ignored_start", busy_a, 1'b1);
      end while (!done_a && n < 120);
      check("r_latency", 128'(n), 128'd40);
      check("r_round1_orig_key", rk_a(1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
      check("r_round10_orig_key", rk_a(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
      @(posedge clk);
      #1;
      check1("r_done_once", done_a, 1'b0);
      check1("r_still_idle", busy_a, 1'b0);
      key_a = KEY128;

      // AES-128, reset asserted at edge 15 of an expansion
      pulse(0);
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check1("x_allkeys_cleared", |keys_a, 1'b0);
      check1("x_busy_cleared", busy_a, 1'b0);
      check1("x_kv_cleared", kv_a, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      pulse(0);
      wait_done(0, n);
      check("x_latency_after_reset", 128'(n), 128'd40);
      check("x_round10", rk_a(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // AES-128, start held high: re-accepted on the first IDLE edge after done
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      wait_done(0, n);
      check("h_latency_first", 128'(n), 128'd40);
      @(posedge clk);
      #1;
      check1("h_restart_busy", busy_a, 1'b1);
      check1("h_restart_kv_cleared", kv_a, 1'b0);
      check("h_restart_round1_cleared", rk_a(1), 128'h0);
      start_a = 1'b0;
      wait_done(0, n);
      check("h_latency_second", 128'(n), 128'd40);
      check1("h_kv_second", kv_a, 1'b1);
      check1("b_idle_end", busy_b | busy_c, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
